// File: rtl/uart_tx_ctrl.sv
// UART transmitter: 8 data bits, optional even/odd parity, one stop bit.
// Serializes one byte per ready/send handshake; done pulses once at the end of each frame.
module uart_tx_ctrl #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       send,
    output logic       ready,
    output logic       done,
    output logic       tx
);

    localparam int unsigned ClksPerBit = CLK_FREQ / BAUD;
    localparam int unsigned CntW       = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(ClksPerBit - 1);
    localparam logic ParEn  = (PARITY_EN != 0);
    localparam logic ParOdd = (PARITY_ODD != 0);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StParity = 3'd3;
    localparam logic [2:0] StStop   = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic            tx_q, tx_d;
    logic            ready_q, ready_d;
    logic            done_q, done_d;
    logic            bit_end;

    assign bit_end = (cnt_q == CntMax);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        ready_d = ready_q;
        done_d  = 1'b0;

        case (state_q)
            StIdle: begin
                tx_d    = 1'b1;
                ready_d = 1'b1;
                if (send) begin
                    shift_d = data;
                    par_d   = (^data) ^ ParOdd;
                    state_d = StStart;
                    tx_d    = 1'b0;
                    ready_d = 1'b0;
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                end
            end

            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    tx_d    = shift_q[0];
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StData: begin
                if (bit_end) begin
                    cnt_d = '0;
                    // Shift right so the next data bit is always at shift_q[1].
                    shift_d = {1'b0, shift_q[7:1]};
                    if (idx_q == 3'd7) begin
                        if (ParEn) begin
                            state_d = StParity;
                            tx_d    = par_q;
                        end else begin
                            state_d = StStop;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    tx_d    = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StStop: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    state_d = StIdle;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
                ready_d = 1'b1;
                cnt_d   = '0;
                idx_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign tx    = tx_q;
    assign ready = ready_q;
    assign done  = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: three instances (even parity, odd parity, no parity) at 16 clks/bit,
// compared cycle by cycle against an expected waveform queue.
module tb_uart_tx_ctrl;

    localparam int Cpb = 16;

    logic       clk = 1'b0;
    logic [2:0] rst_n;
    logic [2:0] send;
    logic [2:0] tx;
    logic [2:0] ready;
    logic [2:0] done;
    logic [7:0] data [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl #(.CLK_FREQ(16), .BAUD(1), .PARITY_EN(1), .PARITY_ODD(0)) u_even (
        .clk(clk), .rst_n(rst_n[0]), .data(data[0]), .send(send[0]),
        .ready(ready[0]), .done(done[0]), .tx(tx[0])
    );
    uart_tx_ctrl #(.CLK_FREQ(16), .BAUD(1), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
        .clk(clk), .rst_n(rst_n[1]), .data(data[1]), .send(send[1]),
        .ready(ready[1]), .done(done[1]), .tx(tx[1])
    );
    uart_tx_ctrl #(.CLK_FREQ(16), .BAUD(1), .PARITY_EN(0), .PARITY_ODD(0)) u_nopar (
        .clk(clk), .rst_n(rst_n[2]), .data(data[2]), .send(send[2]),
        .ready(ready[2]), .done(done[2]), .tx(tx[2])
    );

    typedef struct packed {
        logic tx;
        logic done;
        logic ready;
    } cyc_t;

    typedef struct {
        int         dut;
        logic [7:0] byte_v;
        logic [10:0] bits;   // bit k = k-th transmitted bit (start first)
        int         nbits;
    } vec_t;

    cyc_t exp_q[$];
    vec_t tbl[6];

    task automatic chk1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    function automatic void push_bit(input logic v);
        for (int i = 0; i < Cpb; i++) exp_q.push_back('{tx: v, done: 1'b0, ready: 1'b0});
    endfunction

    function automatic void push_done();
        exp_q.push_back('{tx: 1'b1, done: 1'b1, ready: 1'b1});
    endfunction

    function automatic void push_idle();
        exp_q.push_back('{tx: 1'b1, done: 1'b0, ready: 1'b1});
    endfunction

    function automatic void push_bits(input logic [10:0] bits, input int nbits);
        for (int b = 0; b < nbits; b++) push_bit(bits[b]);
        push_done();
    endfunction

    // Reference frame built from the framing rules: start, 8 data LSB first, parity, stop.
    function automatic void push_model(input int d, input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        push_bit(1'b0);
        for (int i = 0; i < 8; i++) push_bit(b[i]);
        if (d != 2) push_bit(((ones % 2) == 1) ^ (d == 1));
        push_bit(1'b1);
        push_done();
    endfunction

    task automatic check_stream(input int d, input string name);
        int   bad_tx = -1, bad_done = -1, bad_rdy = -1;
        logic a_tx = 1'b0, a_done = 1'b0, a_rdy = 1'b0;
        logic e_tx = 1'b0, e_done = 1'b0, e_rdy = 1'b0;
        cyc_t e;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            e = exp_q[i];
            if (tx[d] !== e.tx && bad_tx < 0) begin
                bad_tx = i; a_tx = tx[d]; e_tx = e.tx;
            end
            if (done[d] !== e.done && bad_done < 0) begin
                bad_done = i; a_done = done[d]; e_done = e.done;
            end
            if (ready[d] !== e.ready && bad_rdy < 0) begin
                bad_rdy = i; a_rdy = ready[d]; e_rdy = e.ready;
            end
        end
        checks += 3;
        if (bad_tx >= 0) begin
            failures++;
            $display("FAIL %s.tx cycle %0d: got %b expected %b", name, bad_tx, a_tx, e_tx);
        end
        if (bad_done >= 0) begin
            failures++;
            $display("FAIL %s.done cycle %0d: got %b expected %b", name, bad_done, a_done, e_done);
        end
        if (bad_rdy >= 0) begin
            failures++;
            $display("FAIL %s.ready cycle %0d: got %b expected %b", name, bad_rdy, a_rdy, e_rdy);
        end
    endtask

    // Expected queue must be filled; sends one byte with a single-cycle send pulse.
    task automatic run_frame(input int d, input logic [7:0] b, input string name);
        @(negedge clk);
        data[d] = b;
        send[d] = 1'b1;
        fork
            begin
                @(negedge clk);
                send[d] = 1'b0;
            end
            check_stream(d, name);
        join
    endtask

    initial begin
        tbl[0] = '{0, 8'h41, 11'b10010000010, 11};
        tbl[1] = '{1, 8'hFF, 11'b11111111110, 11};
        tbl[2] = '{2, 8'h80, 11'b01100000000, 10};
        tbl[3] = '{0, 8'h00, 11'b10000000000, 11};
        tbl[4] = '{1, 8'h00, 11'b11000000000, 11};
        tbl[5] = '{2, 8'hFF, 11'b01111111110, 10};

        rst_n = 3'b000;
        send  = 3'b000;
        for (int d = 0; d < 3; d++) data[d] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk1($sformatf("reset_tx[%0d]", d), tx[d], 1'b1);
            chk1($sformatf("reset_ready[%0d]", d), ready[d], 1'b1);
            chk1($sformatf("reset_done[%0d]", d), done[d], 1'b0);
        end
        rst_n = 3'b111;

        // 0xA5 in flight; at cycle 40 the line carries data bit 1 (=0) when reset hits.
        @(negedge clk);
        data[0] = 8'hA5;
        send[0] = 1'b1;
        @(negedge clk);
        send[0] = 1'b0;
        repeat (40) @(negedge clk);
        chk1("midframe_tx", tx[0], 1'b0);
        chk1("midframe_ready", ready[0], 1'b0);
        #2 rst_n[0] = 1'b0;
        #1;
        chk1("async_reset_tx", tx[0], 1'b1);
        chk1("async_reset_ready", ready[0], 1'b1);
        chk1("async_reset_done", done[0], 1'b0);
        @(negedge clk);
        rst_n[0] = 1'b1;

        for (int i = 0; i < 6; i++) begin
            exp_q.delete();
            push_bits(tbl[i].bits, tbl[i].nbits);
            push_idle();
            run_frame(tbl[i].dut, tbl[i].byte_v, $sformatf("vec%0d", i));
        end

        // send held high across done: 0x55 then 0xAA, contiguous frames.
        @(negedge clk);
        exp_q.delete();
        push_model(0, 8'h55);
        push_model(0, 8'hAA);
        push_idle();
        data[0] = 8'h55;
        send[0] = 1'b1;
        fork
            begin
                @(negedge clk);
                data[0] = 8'hAA;
                repeat (177) @(negedge clk);
                send[0] = 1'b0;
            end
            check_stream(0, "back_to_back");
        join

        // send pulses and data changes during a frame of 0x3C are ignored.
        @(negedge clk);
        exp_q.delete();
        push_model(0, 8'h3C);
        push_idle();
        push_idle();
        data[0] = 8'h3C;
        send[0] = 1'b1;
        fork
            begin
                @(negedge clk);
                send[0] = 1'b0;
                data[0] = 8'h00;
                repeat (30) @(negedge clk);
                send[0] = 1'b1;
                @(negedge clk);
                send[0] = 1'b0;
                repeat (40) @(negedge clk);
                send[0] = 1'b1;
                data[0] = 8'hFF;
                repeat (3) @(negedge clk);
                send[0] = 1'b0;
            end
            check_stream(0, "ignored_send");
        join

        for (int r = 0; r < 12; r++) begin
            int         d;
            logic [7:0] b;
            d = r % 3;
            b = 8'($urandom);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            exp_q.delete();
            push_model(d, b);
            push_idle();
            run_frame(d, b, $sformatf("rand%0d_dut%0d_%02h", r, d, b));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
UART transmitter, 8N1/8E1/8O1 framing. Serializes one byte per handshake onto the BASYS3 USB-UART TX pin (RsTx) at a fixed baud. It is the counterpart of the receive controller, so a loopback or echo top can pair them. Byte input uses a ready/send handshake; a single-cycle done pulse marks the end of each frame.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD, 9600, line rate in bits/s; CLKS_PER_BIT = CLK_FREQ/BAUD, integer-truncated (10416 at defaults)
PARITY_EN, 1, 1 = insert parity bit after data; 0 = no parity bit
PARITY_ODD, 0, 0 = even parity; 1 = odd parity (ignored when PARITY_EN=0)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
data  input  8  byte to transmit; sampled only on accept
send  input  1  request; a byte is accepted when send=1 and ready=1 on a clk edge
ready  output  1  high = idle, can accept a byte
done  output  1  one-cycle pulse at end of stop bit
tx  output  1  serial line, idle high; registered

Behaviour:
- Reset (rst_n=0, asynchronous): tx=1, ready=1, done=0, state IDLE, baud counter=0, bit index=0. Reset mid-frame aborts the frame; tx returns high immediately, with no partial stop bit.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1, ready=1.
  - Accept on edge with send=1: latch data into the shift register, compute parity bit.
  - Even parity bit = XOR of the 8 data bits. Odd parity bit = its inverse.
  - Same edge: go to START, tx<=0, ready<=0, counter<=0.
- Each bit is held exactly CLKS_PER_BIT cycles. The counter counts 0..CLKS_PER_BIT-1; the bit advances on the edge where counter=CLKS_PER_BIT-1.
- START → DATA: tx=data[0]. DATA sends bits LSB first, index 0..7.
- After bit 7: go to PARITY if PARITY_EN=1, else STOP.
- PARITY → STOP, tx=parity bit. STOP: tx=1 for CLKS_PER_BIT cycles.
- End of STOP:
  - done=1 for exactly one cycle.
  - ready=1 on the same edge; state IDLE.
- Frame length: 11×CLKS_PER_BIT cycles with parity, 10× without (114576 / 104160 at defaults). tx falls one cycle after the accepting edge.
- Back-to-back: send held high through done. The next byte is accepted on the first edge ready=1, and its start bit follows immediately. No idle gap beyond the stop bit; the line never glitches.
- send=1 while ready=0 is ignored and not queued. Changes on data after accept do not affect the frame in flight.
- done and ready are mutually consistent: done=1 implies ready=1 in that cycle.
- No combinational path from any input to tx.

Test Plan:
- Reset mid-frame → tx=1 immediately (async); ready=1; done=0; next send transmits cleanly.
  - Overrides for all scenarios: CLK_FREQ=16, BAUD=1 (16 clks/bit), PARITY_EN=1, PARITY_ODD=0.
  - Stimulus: rst_n low 3 cycles, send 0xA5, assert rst_n=0 at cycle 40.
- Single byte 0x41 → tx sequence per 16-cycle bit: 0,1,0,0,0,0,0,1,0,0,1.
  - Parity=0 (0x41 has 2 ones); stop bit 1.
  - done pulses exactly once, 176 cycles after accept; ready low for those 176 cycles.
- PARITY_ODD=1, byte 0xFF → data bits all 1; parity bit=1; frame 0,1×8,1,1.
- PARITY_EN=0, byte 0x80 → tx: 0, 0×7, 1, stop 1; done at 160 cycles.
- send held high with data 0x55 then 0xAA → two contiguous frames; second start bit begins the cycle after done; no extra idle high.
- send pulses and data changes to 0x00 during a frame of 0x3C → ignored; transmitted bits match 0x3C; only one done.
